// File: rtl/acorn128_if.sv
// acorn128_if: stream and datapath-step signals of the ACORN-128 sequencer.
//
// Groups the serial AD/plaintext streams with their ready handshakes, the per-step
// controls sent to the state-update datapath (step_en, mbit, ca, cb), the keystream
// bit returned by the datapath (ks_in) and the registered ciphertext output.
//
// Modports:
//   master - sequencer view: drives ready, step controls and ciphertext;
//            receives stream beats and ks_in.
//   slave  - environment view (stream sources, datapath, ciphertext sink).
interface acorn128_if;
  // Associated-data stream
  logic ad_bit;
  logic ad_valid;
  logic ad_last;
  logic ad_ready;
  // Plaintext stream
  logic pt_bit;
  logic pt_valid;
  logic pt_last;
  logic pt_ready;
  // Datapath step controls and returned keystream bit
  logic step_en;
  logic mbit;
  logic ca;
  logic cb;
  logic ks_in;
  // Ciphertext output
  logic ct_bit;
  logic ct_valid;

  modport master (
    input  ad_bit, ad_valid, ad_last,
    input  pt_bit, pt_valid, pt_last,
    input  ks_in,
    output ad_ready, pt_ready,
    output step_en, mbit, ca, cb,
    output ct_bit, ct_valid
  );

  modport slave (
    output ad_bit, ad_valid, ad_last,
    output pt_bit, pt_valid, pt_last,
    output ks_in,
    input  ad_ready, pt_ready,
    input  step_en, mbit, ca, cb,
    input  ct_bit, ct_valid
  );
endinterface

// File: rtl/acorn128_sequencer.sv
// acorn128_sequencer: phase controller for the ACORN-128 core.
//
// Sequences initialization, associated-data absorption, AD padding, encryption,
// plaintext padding and finalization. Each cycle it tells the state-update stage
// whether to step and supplies that step's message bit and ca/cb controls. It turns
// the returned keystream bit into ciphertext during encryption and captures the
// 128-bit tag from the last 128 finalization steps.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   start           - begin an operation (honoured only when idle)
//   key, iv         - 128-bit key and IV, latched at start
//   ad_none,pt_none - empty AD / empty plaintext flags, latched at start
//   bus             - stream handshakes, step controls, ks_in and ciphertext
//   tag, tag_valid  - captured tag; valid from done until the next start or reset
//   done            - one-cycle completion pulse
//   busy            - high whenever an operation is in progress
module acorn128_sequencer #(
  parameter int unsigned INIT_STEPS  = 1792,
  parameter int unsigned PAD_STEPS   = 256,
  parameter int unsigned FINAL_STEPS = 768
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         ad_none,
  input  logic         pt_none,
  acorn128_if.master   bus,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         done,
  output logic         busy
);

  localparam logic [10:0] InitLast  = 11'(INIT_STEPS - 1);
  localparam logic [10:0] PadLast   = 11'(PAD_STEPS - 1);
  localparam logic [10:0] FinalLast = 11'(FINAL_STEPS - 1);
  // The tag comes from the final 128 steps of finalization.
  localparam logic [10:0] TagFirst  = 11'(FINAL_STEPS - 128);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StAd,
    StAdPad,
    StEnc,
    StEncPad,
    StFinal
  } state_e;

  state_e        state_q, state_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [127:0]  key_q, iv_q;
  logic          ad_none_q, pt_none_q;
  logic [127:0]  tag_q;
  logic          tag_valid_q;
  logic          done_q, done_d;
  logic          ct_bit_q, ct_valid_q;

  logic          init_mbit;
  logic          start_ok;
  logic          ct_accept;
  logic          tag_capture;
  logic [6:0]    tag_idx;

  // Message bit during initialization: key, then IV, then a single inverted key[0]
  // as the domain separator, then the key repeated.
  always_comb begin
    init_mbit = 1'b0;
    if (cnt_q < 11'd128) begin
      init_mbit = key_q[cnt_q[6:0]];
    end else if (cnt_q < 11'd256) begin
      init_mbit = iv_q[cnt_q[6:0]];
    end else if (cnt_q == 11'd256) begin
      init_mbit = ~key_q[0];
    end else begin
      init_mbit = key_q[cnt_q[6:0]];
    end
  end

  // Next-state and per-step controls, all decoded from registered state and counter;
  // only the stream states pass *_valid through to step_en.
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    bus.step_en  = 1'b0;
    bus.mbit     = 1'b0;
    bus.ca       = 1'b0;
    bus.cb       = 1'b0;
    bus.ad_ready = 1'b0;
    bus.pt_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StInit;
      end
      StInit: begin
        bus.step_en = 1'b1;
        bus.mbit    = init_mbit;
        bus.ca      = 1'b1;
        bus.cb      = 1'b1;
        if (cnt_q == InitLast) state_d = ad_none_q ? StAdPad : StAd;
      end
      StAd: begin
        bus.ad_ready = 1'b1;
        bus.step_en  = bus.ad_valid;
        bus.mbit     = bus.ad_bit;
        bus.ca       = 1'b1;
        bus.cb       = 1'b1;
        if (bus.ad_valid && bus.ad_last) state_d = StAdPad;
      end
      StAdPad: begin
        bus.step_en = 1'b1;
        bus.mbit    = (cnt_q == 11'd0);
        bus.ca      = (cnt_q < 11'd128);
        bus.cb      = 1'b1;
        if (cnt_q == PadLast) state_d = pt_none_q ? StEncPad : StEnc;
      end
      StEnc: begin
        bus.pt_ready = 1'b1;
        bus.step_en  = bus.pt_valid;
        bus.mbit     = bus.pt_bit;
        bus.ca       = 1'b1;
        bus.cb       = 1'b0;
        if (bus.pt_valid && bus.pt_last) state_d = StEncPad;
      end
      StEncPad: begin
        bus.step_en = 1'b1;
        bus.mbit    = (cnt_q == 11'd0);
        bus.ca      = (cnt_q < 11'd128);
        bus.cb      = 1'b0;
        if (cnt_q == PadLast) state_d = StFinal;
      end
      StFinal: begin
        bus.step_en = 1'b1;
        bus.mbit    = 1'b0;
        bus.ca      = 1'b1;
        bus.cb      = 1'b1;
        if (cnt_q == FinalLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Step counter: advances with each datapath step and restarts at every state entry.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.step_en) cnt_d = cnt_q + 11'd1;
    if (state_d != state_q) cnt_d = 11'd0;
  end

  assign start_ok    = (state_q == StIdle) && start;
  assign ct_accept   = (state_q == StEnc) && bus.pt_valid;
  assign tag_capture = (state_q == StFinal) && (cnt_q >= TagFirst);
  assign tag_idx     = 7'(cnt_q - TagFirst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 11'd0;
      key_q       <= '0;
      iv_q        <= '0;
      ad_none_q   <= 1'b0;
      pt_none_q   <= 1'b0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ct_bit_q    <= 1'b0;
      ct_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      ct_valid_q <= ct_accept;
      if (ct_accept) ct_bit_q <= bus.pt_bit ^ bus.ks_in;

      if (start_ok) begin
        key_q       <= key;
        iv_q        <= iv;
        ad_none_q   <= ad_none;
        pt_none_q   <= pt_none;
        tag_q       <= '0;
        tag_valid_q <= 1'b0;
      end

      if (tag_capture) tag_q[tag_idx] <= bus.ks_in;
      if (done_d) tag_valid_q <= 1'b1;
    end
  end

  assign bus.ct_bit   = ct_bit_q;
  assign bus.ct_valid = ct_valid_q;
  assign tag          = tag_q;
  assign tag_valid    = tag_valid_q;
  assign done         = done_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_acorn128_sequencer.sv
module tb_acorn128_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] iv;
  logic         ad_none;
  logic         pt_none;
  logic [127:0] tag;
  logic         tag_valid;
  logic         done;
  logic         busy;

  acorn128_if bus ();

  acorn128_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .iv        (iv),
    .ad_none   (ad_none),
    .pt_none   (pt_none),
    .bus       (bus),
    .tag       (tag),
    .tag_valid (tag_valid),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle offset after start vs expected {step_en, mbit, ca, cb, busy, done}.
  typedef struct {
    int         k;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[19];

  logic [7:0] adv;
  logic [3:0] ptv;
  int         n_step, n_mb, done_k, nb, ad_steps, w;
  int         mb_pos[3];

  initial begin
    rst = 1'b1; start = 1'b0; key = '0; iv = '0; ad_none = 1'b1; pt_none = 1'b1;
    bus.ad_bit = 1'b0; bus.ad_valid = 1'b0; bus.ad_last = 1'b0;
    bus.pt_bit = 1'b0; bus.pt_valid = 1'b0; bus.pt_last = 1'b0;
    bus.ks_in  = 1'b0;

    // key = 1, iv = all ones, no AD, no plaintext.
    vecs[0]  = '{0,    6'b111110};  // INIT key[0]
    vecs[1]  = '{1,    6'b101110};  // key[1]
    vecs[2]  = '{127,  6'b101110};  // key[127]
    vecs[3]  = '{128,  6'b111110};  // iv[0]
    vecs[4]  = '{255,  6'b111110};  // iv[127]
    vecs[5]  = '{256,  6'b101110};  // ~key[0]
    vecs[6]  = '{384,  6'b111110};  // key[0] again
    vecs[7]  = '{1791, 6'b101110};  // key[127], last INIT
    vecs[8]  = '{1792, 6'b111110};  // AD_PAD i=0
    vecs[9]  = '{1919, 6'b101110};  // AD_PAD i=127
    vecs[10] = '{1920, 6'b100110};  // AD_PAD i=128, ca drops
    vecs[11] = '{2047, 6'b100110};  // AD_PAD i=255
    vecs[12] = '{2048, 6'b111010};  // ENC_PAD i=0
    vecs[13] = '{2176, 6'b100010};  // ENC_PAD i=128
    vecs[14] = '{2303, 6'b100010};  // ENC_PAD i=255
    vecs[15] = '{2304, 6'b101110};  // FINAL i=0
    vecs[16] = '{3071, 6'b101110};  // FINAL i=767
    vecs[17] = '{3072, 6'b000001};  // IDLE with done
    vecs[18] = '{3073, 6'b000000};  // idle

    // Reset state
    tick(); tick();
    chk("rst_outs", {bus.step_en, bus.ad_ready, bus.pt_ready, bus.mbit, bus.ca, bus.cb,
                     bus.ct_bit, bus.ct_valid, done, tag_valid, busy}, 11'd0);
    chk("rst_tag", tag, 128'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);

    // Table-driven full run; ks_in follows the cycle parity so the tag alternates.
    key = 128'h1; iv = '1; ad_none = 1'b1; pt_none = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 3073; k++) begin
      bus.ks_in = k[0];
      #1;
      for (int v = 0; v < 19; v++) begin
        if (vecs[v].k == k) begin
          chk($sformatf("vec_k%0d", k),
              {bus.step_en, bus.mbit, bus.ca, bus.cb, busy, done}, vecs[v].exp);
        end
      end
      tick();
    end
    chk("tag_alt", tag, {64{2'b10}});
    chk("tag_valid_set", tag_valid, 1'b1);
    repeat (20) tick();
    chk("tag_valid_hold", tag_valid, 1'b1);
    chk("tag_hold", tag, {64{2'b10}});

    // key = iv = 0: count steps and mbit ones; restart in the done cycle.
    key = '0; iv = '0; start = 1'b1;
    tick();
    start = 1'b0;
    n_step = 0; n_mb = 0; done_k = -1;
    for (int j = 0; j < 3; j++) mb_pos[j] = -1;
    for (int k = 0; k <= 3072; k++) begin
      #1;
      if (bus.step_en === 1'b1) begin
        n_step++;
        if (bus.mbit === 1'b1) begin
          if (n_mb < 3) mb_pos[n_mb] = k;
          n_mb++;
        end
      end
      if (done === 1'b1) done_k = k;
      if (k == 3072) begin
        key = 128'h5; iv = '0; ad_none = 1'b0; pt_none = 1'b0; start = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    chk("zero_steps", n_step, 3072);
    chk("zero_mbit_ones", n_mb, 3);
    chk("zero_mbit_pos0", mb_pos[0], 256);
    chk("zero_mbit_pos1", mb_pos[1], 1792);
    chk("zero_mbit_pos2", mb_pos[2], 2048);
    chk("zero_done_k", done_k, 3072);

    // Start taken in the done cycle: now at INIT i=0.
    #1;
    chk("restart_busy", busy, 1'b1);
    chk("restart_mbit_i0", bus.mbit, 1'b1);
    chk("restart_tag_valid_clr", tag_valid, 1'b0);
    chk("restart_tag_clr", tag, 128'd0);
    tick(); #1;
    chk("restart_mbit_i1", bus.mbit, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("restart_mbit_i2", bus.mbit, 1'b1);
    tick(); #1;
    chk("busy_start_ignored", bus.mbit, 1'b0);

    // Reset at INIT i=500.
    repeat (497) tick();
    rst = 1'b1;
    #1;
    chk("midrst_outs", {bus.step_en, bus.ad_ready, bus.pt_ready, bus.mbit, bus.ca, bus.cb,
                        bus.ct_bit, bus.ct_valid, done, tag_valid, busy}, 11'd0);
    tick();
    rst = 1'b0;
    tick(); #1;
    chk("midrst_idle", {busy, bus.step_en}, 2'b00);

    // Fresh start with AD and plaintext present.
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("fresh_i0", {busy, bus.mbit}, 2'b11);
    tick();
    bus.ad_valid = 1'b1; bus.pt_valid = 1'b1;
    #1;
    chk("fresh_i1", bus.mbit, 1'b0);
    chk("oop_ready", {bus.ad_ready, bus.pt_ready, bus.step_en}, 3'b001);
    bus.ad_valid = 1'b0; bus.pt_valid = 1'b0;
    repeat (1791) tick();

    // AD: 10110011 with valid low on alternate cycles.
    adv = 8'b10110011; nb = 0; ad_steps = 0;
    for (int c = 0; c < 16; c++) begin
      bus.ad_valid = c[0];
      bus.ad_bit   = c[0] ? adv[7-nb] : 1'b0;
      bus.ad_last  = c[0] && (nb == 7);
      #1;
      chk($sformatf("ad_ready_c%0d", c), bus.ad_ready, 1'b1);
      chk($sformatf("ad_step_c%0d", c), bus.step_en, c[0]);
      if (bus.step_en === 1'b1) ad_steps++;
      if (c[0]) begin
        chk($sformatf("ad_ctl_b%0d", nb), {bus.mbit, bus.ca, bus.cb}, {adv[7-nb], 2'b11});
        nb++;
      end
      tick();
    end
    bus.ad_valid = 1'b0; bus.ad_last = 1'b0;
    #1;
    chk("ad_steps", ad_steps, 8);
    chk("adpad_entry", {bus.ad_ready, bus.step_en, bus.mbit, bus.ca, bus.cb}, 5'b01111);
    repeat (256) tick();

    // ENC: 1010 with ks_in tied high.
    #1;
    chk("enc_ready", bus.pt_ready, 1'b1);
    ptv = 4'b1010;
    bus.ks_in = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.pt_valid = 1'b1;
      bus.pt_bit   = ptv[3-b];
      bus.pt_last  = (b == 3);
      #1;
      chk($sformatf("enc_step_b%0d", b), bus.step_en, 1'b1);
      chk($sformatf("enc_ctl_b%0d", b), {bus.mbit, bus.ca, bus.cb}, {ptv[3-b], 2'b10});
      if (b == 0) chk("ct_valid_pre", bus.ct_valid, 1'b0);
      else chk($sformatf("ct_b%0d", b - 1), {bus.ct_valid, bus.ct_bit}, {1'b1, ~ptv[4-b]});
      tick();
    end
    bus.pt_valid = 1'b0; bus.pt_last = 1'b0;
    #1;
    chk("ct_b3", {bus.ct_valid, bus.ct_bit}, {1'b1, ~ptv[0]});
    chk("encpad_entry", {bus.pt_ready, bus.step_en, bus.mbit, bus.ca, bus.cb}, 5'b01110);
    tick(); #1;
    chk("ct_valid_drop", bus.ct_valid, 1'b0);

    // Remainder of ENC_PAD plus FINAL with ks_in low.
    bus.ks_in = 1'b0;
    w = 0;
    while (done !== 1'b1 && w < 1500) begin
      tick();
      w++;
    end
    chk("done_latency", w, 1023);
    chk("tag_zero", tag, 128'd0);
    chk("tag_valid_final", tag_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
